fetch_stage: RTL and testbench

//  Instruction-fetch producer for the IF->ID interface: owns the PC, issues word reads to instruction memory,

---
 rtl/arm_defs.sv | 15 +
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_defs.sv
// Shared ARM-side constants and the fetch-queue entry layout.
package arm_defs;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] ARM_NOP = 32'hE1A0_0000;  // MOV r0,r0 (cond AL)
  localparam logic [WORD_W-1:0] PC_INC  = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;     // fetch address + 4
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: single-cycle request pulse, in-order valid/data return.
interface fetch_stage_if;
  import arm_defs::*;
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [WORD_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc+4, instruction} entries with synchronous clear.
module fetch_queue
  import arm_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int          CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps one imem read in flight, queues returned words and
// drives the IF/ID register with freeze hold and branch redirect/flush.
module fetch_stage
  import arm_defs::*;
#(
  parameter int unsigned       QDEPTH    = 2,
  parameter logic [WORD_W-1:0] NOP_INSTR = ARM_NOP,
  parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  fetch_stage_if.master     imem,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] instruction,
  output logic              valid_out
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [WORD_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
  logic [WORD_W-1:0] pc_out_q, pc_out_d, instr_q, instr_d;
  logic              out_q, out_d, disc_q, disc_d, valid_q, valid_d;
  logic              resp, push, pop, issue, q_full, q_empty;
  logic [CW:0]       occ;
  logic [CW-1:0]     q_count;
  fetch_entry_t      q_din, q_dout;

  fetch_queue #(.DEPTH(QDEPTH), .CW(CW)) u_queue (
    .clk, .rst, .push, .pop, .clear(branch_taken), .din(q_din), .dout(q_dout),
    .full(q_full), .empty(q_empty), .count(q_count)
  );

  always_comb begin
    resp  = imem.imem_rvalid & out_q;
    pop   = ~branch_taken & ~freeze & ~q_empty;
    push  = resp & ~disc_q & ~branch_taken;
    // A kept in-flight word owns a queue slot whether it lands now or later.
    occ   = {1'b0, q_count} - (CW+1)'(pop) + (CW+1)'(out_q & ~disc_q);
    issue = rst & ~branch_taken & (~out_q | resp) & (occ < (CW+1)'(QDEPTH));
    q_din = '{pc: req_addr_q + PC_INC, instr: imem.imem_rdata};

    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    disc_d     = disc_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    if (branch_taken) begin
      pc_d    = word_align(branch_addr);
      out_d   = out_q & ~imem.imem_rvalid;
      disc_d  = out_q & ~imem.imem_rvalid;  // a same-cycle word is simply dropped
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      if (resp) begin
        out_d  = 1'b0;
        disc_d = 1'b0;
      end
      if (issue) begin
        pc_d       = pc_q + PC_INC;
        req_addr_d = pc_q;
        out_d      = 1'b1;
      end
      if (!freeze) begin
        if (!q_empty) begin
          pc_out_d = q_dout.pc;
          instr_d  = q_dout.instr;
          valid_d  = 1'b1;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      out_q      <= 1'b0;
      disc_q     <= 1'b0;
      pc_out_q   <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) if (rst && push) assert (!q_full);

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;
  assign pc_out         = pc_out_q;
  assign instruction    = instr_q;
  assign valid_out      = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model returns the address as data, and
// the reference is the architectural fetch stream (consecutive words from the last target).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0, rst = 1'b1, freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_addr = '0, pc_out, instruction;
  logic        valid_out;
  int          n_chk = 0, n_pass = 0;

  fetch_stage_if bus();

  fetch_stage #(.QDEPTH(2), .NOP_INSTR(32'hE1A0_0000), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem(bus), .pc_out(pc_out),
    .instruction(instruction), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // memory model + observation state
  int          cyc = 0, lat_min = 1, lat_max = 1, last_due = 0;
  logic [31:0] pend_a[$];
  int          pend_d[$];
  logic        req_now, loaded;
  logic [31:0] req_addr_now;
  logic [31:0] obs_pc[$], obs_in[$];

  // One cycle: drive memory response, sample request, clock, record any new IF/ID load.
  task automatic tick();
    int d;
    bit ld_ok;
    if (pend_d.size() > 0 && pend_d[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend_a.pop_front();
      void'(pend_d.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #2;
    req_now = bus.imem_req;
    req_addr_now = bus.imem_addr;
    if (req_now) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_a.push_back(req_addr_now);
      pend_d.push_back(d);
    end
    ld_ok = rst && !branch_taken && !freeze;
    @(posedge clk); #1;
    cyc++;
    loaded = ld_ok && valid_out;
    if (loaded) begin
      obs_pc.push_back(pc_out);
      obs_in.push_back(instruction);
    end
  endtask

  task automatic run_until_load(input int budget, output bit got);
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      got = loaded;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.imem_rvalid = 1'b0;
    tick(); tick();
    n_chk++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else n_pass++;
    n_chk++; if (instruction !== NOP) $display("FAIL reset_instr: got %h want %h", instruction, NOP); else n_pass++;
    n_chk++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h want 0", pc_out); else n_pass++;
    n_chk++; if (req_now !== 1'b0) $display("FAIL reset_req: got %b want 0", req_now); else n_pass++;
    n_chk++; if (req_addr_now !== 32'h0) $display("FAIL reset_addr: got %h want 0", req_addr_now); else n_pass++;
  endtask

  task automatic test_stream();
    int first = -1;
    lat_min = 1; lat_max = 1;
    obs_pc.delete(); obs_in.delete();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (first < 0 && valid_out === 1'b1) first = k;
    end
    n_chk++; if (first !== 3) $display("FAIL stream_first_valid: got cycle %0d want 3", first); else n_pass++;
    n_chk++; if (obs_pc.size() !== 10) $display("FAIL stream_count: got %0d want 10", obs_pc.size()); else n_pass++;
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_chk++; if (obs_pc[i] !== 32'(4*(i+1))) $display("FAIL stream_pc[%0d]: got %h want %h", i, obs_pc[i], 4*(i+1)); else n_pass++;
      n_chk++; if (obs_in[i] !== 32'(4*i)) $display("FAIL stream_instr[%0d]: got %h want %h", i, obs_in[i], 4*i); else n_pass++;
    end
  endtask

  task automatic test_freeze();
    logic [31:0] pp, pi;
    logic pv;
    lat_min = 1; lat_max = 1;
    branch_taken = 1'b1; branch_addr = 32'h200; tick(); branch_taken = 1'b0;
    obs_pc.delete(); obs_in.delete();
    for (int k = 0; k < 6; k++) tick();
    pp = pc_out; pi = instruction; pv = valid_out;
    freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++; if (pc_out !== pp || instruction !== pi || valid_out !== pv)
        $display("FAIL freeze_hold[%0d]: got %h/%h/%b want %h/%h/%b", k, pc_out, instruction, valid_out, pp, pi, pv);
      else n_pass++;
      if (k >= 1) begin
        n_chk++; if (req_now !== 1'b0) $display("FAIL freeze_req_stop[%0d]: got %b want 0", k, req_now); else n_pass++;
      end
    end
    freeze = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_chk++; if (obs_pc.size() !== 10) $display("FAIL freeze_count: got %0d want 10", obs_pc.size()); else n_pass++;
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_chk++; if (obs_pc[i] !== 32'h204 + 32'(4*i) || obs_in[i] !== 32'h200 + 32'(4*i))
        $display("FAIL freeze_order[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_in[i], 32'h204 + 32'(4*i), 32'h200 + 32'(4*i));
      else n_pass++;
    end
  endtask

  task automatic test_branch_inflight();
    bit got, seen;
    logic [31:0] fr = '0;
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 6; k++) tick();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = req_now; end
    n_chk++; if (!seen) $display("FAIL br_wait_req: got none want request"); else n_pass++;
    branch_taken = 1'b1; branch_addr = 32'h100; tick(); branch_taken = 1'b0;
    n_chk++; if (valid_out !== 1'b0 || instruction !== NOP)
      $display("FAIL br_bubble: got %b/%h want 0/%h", valid_out, instruction, NOP); else n_pass++;
    obs_pc.delete(); obs_in.delete();
    seen = 0; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (req_now && !seen) begin seen = 1; fr = req_addr_now; end
      got = loaded;
    end
    n_chk++; if (!got) $display("FAIL br_timeout: got no load want load"); else n_pass++;
    n_chk++; if (fr !== 32'h100) $display("FAIL br_first_req: got %h want 100", fr); else n_pass++;
    if (got) begin
      n_chk++; if (obs_pc[0] !== 32'h104 || obs_in[0] !== 32'h100)
        $display("FAIL br_first_load: got %h/%h want 104/100", obs_pc[0], obs_in[0]); else n_pass++;
    end
  endtask

  task automatic test_branch_freeze_rvalid();
    bit got, seen;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 8; k++) tick();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = req_now; end
    n_chk++; if (!seen) $display("FAIL bfr_wait_req: got none want request"); else n_pass++;
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h100; tick();
    freeze = 1'b0; branch_taken = 1'b0;
    n_chk++; if (valid_out !== 1'b0 || instruction !== NOP)
      $display("FAIL bfr_bubble: got %b/%h want 0/%h", valid_out, instruction, NOP); else n_pass++;
    obs_pc.delete(); obs_in.delete();
    tick();
    n_chk++; if (req_now !== 1'b1 || req_addr_now !== 32'h100)
      $display("FAIL bfr_next_fetch: got %b/%h want 1/100", req_now, req_addr_now); else n_pass++;
    run_until_load(20, got);
    n_chk++; if (!got || obs_pc[0] !== 32'h104 || obs_in[0] !== 32'h100)
      $display("FAIL bfr_first_load: got %0d loads want pc 104 instr 100", obs_pc.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    bit got1, got2;
    lat_min = 1; lat_max = 1;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC; tick(); branch_taken = 1'b0;
    obs_pc.delete(); obs_in.delete();
    run_until_load(20, got1);
    run_until_load(20, got2);
    n_chk++; if (!(got1 && got2)) $display("FAIL wrap_timeout: got %0d loads want 2", obs_pc.size()); else n_pass++;
    if (got1 && got2) begin
      n_chk++; if (obs_pc[0] !== 32'h0 || obs_in[0] !== 32'hFFFF_FFFC)
        $display("FAIL wrap_first: got %h/%h want 0/fffffffc", obs_pc[0], obs_in[0]); else n_pass++;
      n_chk++; if (obs_pc[1] !== 32'h4 || obs_in[1] !== 32'h0)
        $display("FAIL wrap_second: got %h/%h want 4/0", obs_pc[1], obs_in[1]); else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    bit got, seen;
    logic [31:0] fr = 32'hFFFF_FFFF;
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 6; k++) tick();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = req_now; end
    n_chk++; if (!seen) $display("FAIL rstm_wait_req: got none want request"); else n_pass++;
    rst = 1'b0; #1;
    n_chk++; if (valid_out !== 1'b0 || instruction !== NOP || pc_out !== 32'h0)
      $display("FAIL rstm_async: got %b/%h/%h want 0/%h/0", valid_out, instruction, pc_out, NOP); else n_pass++;
    tick(); tick();
    n_chk++; if (req_now !== 1'b0) $display("FAIL rstm_req_in_reset: got %b want 0", req_now); else n_pass++;
    rst = 1'b1;
    obs_pc.delete(); obs_in.delete();
    seen = 0; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (req_now && !seen) begin seen = 1; fr = req_addr_now; end
      got = loaded;
    end
    n_chk++; if (fr !== 32'h0) $display("FAIL rstm_first_req: got %h want 0", fr); else n_pass++;
    n_chk++; if (!got || obs_pc[0] !== 32'h4 || obs_in[0] !== 32'h0)
      $display("FAIL rstm_first_load: got %0d loads want pc 4 instr 0", obs_pc.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_a, tgt, pp, pi;
    logic pv;
    bit br, fz;
    int loads = 0;
    lat_min = 1; lat_max = 3;
    tgt = $urandom & 32'h0000_FFFF;
    branch_taken = 1'b1; branch_addr = tgt; tick(); branch_taken = 1'b0;
    exp_a = tgt & ~32'h3;
    obs_pc.delete(); obs_in.delete();
    for (int k = 0; k < 400; k++) begin
      br = ($urandom_range(99, 0) < 4);
      fz = ($urandom_range(99, 0) < 25);
      tgt = $urandom;
      pp = pc_out; pi = instruction; pv = valid_out;
      branch_taken = br; freeze = fz; branch_addr = tgt;
      tick();
      if (loaded) begin
        n_chk++; if (pc_out !== exp_a + 32'd4 || instruction !== exp_a)
          $display("FAIL rnd_load[%0d]: got %h/%h want %h/%h", k, pc_out, instruction, exp_a + 32'd4, exp_a);
        else n_pass++;
        exp_a = exp_a + 32'd4;
        loads++;
      end
      if (br) begin
        n_chk++; if (valid_out !== 1'b0) $display("FAIL rnd_branch_bubble[%0d]: got %b want 0", k, valid_out); else n_pass++;
        exp_a = tgt & ~32'h3;
      end else if (fz) begin
        n_chk++; if (pc_out !== pp || instruction !== pi || valid_out !== pv)
          $display("FAIL rnd_freeze_hold[%0d]: got %h/%h/%b want %h/%h/%b", k, pc_out, instruction, valid_out, pp, pi, pv);
        else n_pass++;
      end
    end
    branch_taken = 1'b0; freeze = 1'b0;
    n_chk++; if (loads <= 40) $display("FAIL rnd_throughput: got %0d loads want >40", loads); else n_pass++;
  endtask

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    #1;
    test_reset();
    test_stream();
    test_freeze();
    test_branch_inflight();
    test_branch_freeze_rvalid();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
